tcb_man_bist: RTL and testbench
===============================

# tcb_man_bist

Synthesizable TCB manager that runs a write-then-read-back memory self-test over a word-aligned address range. It drives the manager end of a `tcb_if`, honours subordinate backpressure, and supports any fixed response delay `DLY`. It is used both as on-chip BIST for TCB memories and as a self-checking stimulus source against `tcb_vip_sub` in benches. It reports a saturating mismatch/bus-error count at completion.

## Interface
- `ABW`, 32, address bus width; must equal `tcb.ABW`.
- `DBW`, 32, data bus width; must equal `tcb.DBW`.
- `SLW`, 8, selection (byte) width; `BEW = DBW/SLW`.
- `DLY`, 1, response delay in cycles, ≥0; must equal `tcb.DLY`.
- `PAT`, `'h5A5A_5A5A`, `DBW`-bit XOR pattern for data generation.
- `ECW`, 16, error counter width.
- `clk`  in  1  clock; the same net drives `tcb.clk`.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle start request; sampled only in IDLE.
- `base`  in  ABW  start byte address; low `log2(BEW)` bits are ignored (treated as 0).
- `len`  in  ABW  number of words to test; sampled with `start`.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  one-cycle completion pulse.
- `err_cnt`  out  ECW  error count; valid while `done` is high and held until the next accepted `start`.
- `tcb`  `tcb_if.man`  —  TCB manager port (`vld`, `wen`, `adr`, `ben`, `wdt`, `rpt`, `lck` driven; `rdy`, `rdt`, `err`, `rsp` used).

## Operation
- States: IDLE, WR, WR_DRN, RD, RD_DRN, DONE. All state and outputs are registered.
- IDLE: `start`=1 latches `base`, `len`, clears the index `i` and `err_cnt`. If `len`=0, go to DONE; otherwise go to WR.
- Word `i`: `adr = base + i*BEW`, `ben` all ones, `wdt = PAT ^ i` (with `i` zero-extended or truncated to `DBW`), `rpt`=0, `lck`=0.
- WR: `vld`=1, `wen`=1. Each `trn` increments `i`. When `trn` occurs with `i == len-1`, go to WR_DRN with `vld`=0 and `i`=0.
- WR_DRN: `vld`=0. Stay while the outstanding counter is nonzero; go to RD on the first edge at which the registered count is 0.
- RD: `vld`=1, `wen`=0, same address/index sequence. When the last `trn` occurs, go to RD_DRN.
- RD_DRN: wait for the outstanding count to reach 0, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Outstanding counter (width `clog2(DLY+2)`):
  - increments on `trn`, decrements on `rsp`;
  - when both occur in the same cycle, the count is unchanged;
  - with `DLY`=0, `trn` and `rsp` always coincide.
- Expected-data pipeline (`DLY` stages, shifted every cycle):
  - stage 0 loads {`wen`, `PAT^i`} on `trn`, and loads X/invalid otherwise;
  - with `DLY`=0, the compare uses the current-cycle values.
- On each `rsp`, `err_cnt` increments by 1 if `tcb.err`=1, or if the response is a read and `rdt` differs from expected (full word compare). Both conditions together still count as a single increment. The counter saturates at all ones.
- `start` in any state other than IDLE is ignored.
- `rst` asserted at any time:
  - immediately forces `vld`=0, `busy`=0, `done`=0, `err_cnt`=0, state IDLE, counters 0;
  - in-flight responses arriving after release are discarded (outstanding count is 0, so they are not counted).
- Reset values: `vld`=0, `wen`=0, `adr`=0, `ben`=0, `wdt`=0, `rpt`=0, `lck`=0, `busy`=0, `done`=0, `err_cnt`=0.

## Timing
- Edge 0 is the edge that samples `start`. For `len=n≥1`, `DLY=d`, and `rdy` constantly 1:
  - write `trn` occurs at edges 1..n;
  - RD is entered at edge n+d+1;
  - read `trn` occurs at edges n+d+2..2n+d+1;
  - DONE is entered at edge 2n+2d+2, so `done` is high during the following cycle.
- With `len`=0, `done` is high in the cycle immediately after edge 0.
- Each `rdy`=0 cycle during WR or RD delays all later events by exactly one cycle.
- `vld` stays high continuously while in WR and RD (no bubbles). Address and data change only on `trn`.
- `busy` falls in the same cycle `done` rises.

## Test plan
- `len`=4, `base`='h100, `DLY`=1, `rdy`=1, ideal memory:
  - writes to 'h100, 'h104, 'h108, 'h10C with `wdt` = PAT^0..PAT^3;
  - `done` at edge 12 with `err_cnt`=0.
- Same as above with `DLY`=0 and `DLY`=3 → `done` at edges 10 and 16 respectively, `err_cnt`=0.
- `len`=8, subordinate inserts 2 backpressure cycles before every request → `done` 32 edges later than the no-backpressure case; `adr`/`wdt` stable while `rdy`=0.
- `len`=4, memory corrupts word 2 on readback, and subordinate returns `err`=1 on write 1 → `err_cnt`=2.
- `len`=0 → no `vld`, `done` in the cycle after `start`, `err_cnt`=0. `start` pulsed while `busy` → ignored.
- `rst` asserted during RD with 1 response outstanding → `vld`, `busy`, `err_cnt` go to 0 immediately; the late response is not counted; a following `start` with `len`=2 completes with `err_cnt`=0.

Source files
------------

// File: rtl/tcb_man_bist_if.sv
// TCB bus bundle: manager request, subordinate response,
// with transfer and delayed-response strobes derived here.
interface tcb_if #(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned SLW = 8,
  parameter int unsigned DLY = 1
)(
  input logic clk
);
  localparam int unsigned BEW = DBW / SLW;

  logic           vld;
  logic           wen;
  logic [ABW-1:0] adr;
  logic [BEW-1:0] ben;
  logic [DBW-1:0] wdt;
  logic           rpt;
  logic           lck;
  logic           rdy;
  logic [DBW-1:0] rdt;
  logic           err;
  logic           trn;
  logic           rsp;

  assign trn = vld & rdy;

  // Response strobe has no reset: a response in flight still
  // arrives after the manager is reset.
  if (DLY == 0) begin : g_nodly
    assign rsp = trn;
  end else begin : g_dly
    logic [DLY-1:0] sr;
    always_ff @(posedge clk) sr <= DLY'({sr, trn});
    assign rsp = sr[DLY-1];
  end

  modport man (
    input  clk, trn, rsp, rdy, rdt, err,
    output vld, wen, adr, ben, wdt, rpt, lck
  );

  modport sub (
    input  clk, trn, rsp, vld, wen, adr, ben, wdt, rpt, lck,
    output rdy, rdt, err
  );
endinterface

// File: rtl/tcb_man_bist.sv
// TCB manager memory self-test: write PAT^i over a word range,
// read it back, count mismatches and bus errors.
module tcb_man_bist #(
  parameter int unsigned    ABW = 32,
  parameter int unsigned    DBW = 32,
  parameter int unsigned    SLW = 8,
  parameter int unsigned    DLY = 1,
  parameter logic [DBW-1:0] PAT = DBW'('h5A5A_5A5A),
  parameter int unsigned    ECW = 16
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ABW-1:0] base,
  input  logic [ABW-1:0] len,
  output logic           busy,
  output logic           done,
  output logic [ECW-1:0] err_cnt,
  tcb_if.man             tcb
);
  localparam int unsigned BEW = DBW / SLW;
  localparam int unsigned OCW = $clog2(DLY + 2);
  localparam logic [ABW-1:0] AMSK = ~ABW'(BEW - 1);
  localparam logic [ABW-1:0] STEP = ABW'(BEW);

  typedef enum logic [2:0] {
    IDLE, WR, WR_DRN, RD, RD_DRN, DONE
  } state_t;

  state_t         state, state_n;
  logic           vld_q, vld_n;
  logic           wen_q, wen_n;
  logic [ABW-1:0] adr_q, adr_n;
  logic [BEW-1:0] ben_q, ben_n;
  logic [DBW-1:0] wdt_q, wdt_n;
  logic [ABW-1:0] idx, idx_n;
  logic [ABW-1:0] base_q, base_n;
  logic [ABW-1:0] len_q, len_n;
  logic           busy_n, done_n;
  logic [OCW-1:0] ocnt;
  logic           last, go;
  logic           rsp_ok, rd_bad, hit;
  logic [DBW+1:0] exp_cur, exp_q;

  assign last = (idx == len_q - ABW'(1));
  assign go   = (state == IDLE) && start;

  always_comb begin
    state_n = state;
    vld_n   = vld_q;
    wen_n   = wen_q;
    adr_n   = adr_q;
    ben_n   = ben_q;
    wdt_n   = wdt_q;
    idx_n   = idx;
    base_n  = base_q;
    len_n   = len_q;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        base_n = base & AMSK;
        len_n  = len;
        idx_n  = '0;
        adr_n  = base & AMSK;
        ben_n  = '1;
        wdt_n  = PAT;
        wen_n  = 1'b1;
        if (len == '0) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          state_n = WR;
          vld_n   = 1'b1;
          busy_n  = 1'b1;
        end
      end
      WR, RD: if (tcb.trn) begin
        if (last) begin
          state_n = (state == WR) ? WR_DRN : RD_DRN;
          vld_n   = 1'b0;
          idx_n   = '0;
          adr_n   = base_q;
          wdt_n   = PAT;
        end else begin
          idx_n = idx + ABW'(1);
          adr_n = adr_q + STEP;
          wdt_n = PAT ^ DBW'(idx + ABW'(1));
        end
      end
      WR_DRN: if (ocnt == '0) begin
        state_n = RD;
        vld_n   = 1'b1;
        wen_n   = 1'b0;
      end
      RD_DRN: if (ocnt == '0) begin
        state_n = DONE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      vld_q  <= 1'b0;
      wen_q  <= 1'b0;
      adr_q  <= '0;
      ben_q  <= '0;
      wdt_q  <= '0;
      idx    <= '0;
      base_q <= '0;
      len_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      vld_q  <= vld_n;
      wen_q  <= wen_n;
      adr_q  <= adr_n;
      ben_q  <= ben_n;
      wdt_q  <= wdt_n;
      idx    <= idx_n;
      base_q <= base_n;
      len_q  <= len_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  assign tcb.vld = vld_q;
  assign tcb.wen = wen_q;
  assign tcb.adr = adr_q;
  assign tcb.ben = ben_q;
  assign tcb.wdt = wdt_q;
  assign tcb.rpt = 1'b0;
  assign tcb.lck = 1'b0;

  // Top bit marks a real transfer, next bit is the write flag.
  assign exp_cur = {tcb.trn, wen_q, wdt_q};

  if (DLY == 0) begin : g_nodly
    assign exp_q  = exp_cur;
    assign rsp_ok = tcb.rsp;
  end else begin : g_dly
    logic [DBW+1:0] pipe [DLY];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < DLY; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= exp_cur;
        for (int k = 1; k < DLY; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign exp_q  = pipe[DLY-1];
    assign rsp_ok = tcb.rsp && (ocnt != '0);
  end

  assign rd_bad = exp_q[DBW+1] && !exp_q[DBW]
               && (tcb.rdt != exp_q[DBW-1:0]);
  assign hit    = rsp_ok && (tcb.err || rd_bad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ocnt <= '0;
    end else if (tcb.trn && !rsp_ok) begin
      ocnt <= ocnt + OCW'(1);
    end else if (!tcb.trn && rsp_ok) begin
      ocnt <= ocnt - OCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (go) begin
      err_cnt <= '0;
    end else if (hit && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ECW'(1);
    end
  end
endmodule

// File: tb/tb_tcb_man_bist.sv
// Bench for tcb_man_bist: three instances (DLY 0/1/3) each with
// a memory subordinate; timing and error counts from a model.
module tb_tcb_man_bist;
  localparam logic [31:0] PAT = 32'h5A5A_5A5A;

  typedef struct packed {
    logic        wen;
    logic [31:0] adr;
    logic [31:0] wdt;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [2:0]  start_v;
  logic [31:0] base_r, len_r, base_al;
  int          bp, err_mode, corrupt_idx;
  logic [2:0]  done_v, busy_v, vld_v, wen_v;
  logic [15:0] ec_v  [3];
  logic [31:0] adr_v [3];
  logic [31:0] wdt_v [3];
  logic [3:0]  ben_v [3];
  ev_t         ev_q [$];
  int          stab_bad;
  int          total, bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_u
    localparam int unsigned D = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    tcb_if #(.ABW(32), .DBW(32), .SLW(8), .DLY(D)) bus (.clk(clk));
    logic        bsy, dn;
    logic [15:0] ec;
    logic [31:0] mem [64];
    logic [31:0] cur_dat;
    logic        cur_err;
    int          wc;

    tcb_man_bist #(
      .ABW(32), .DBW(32), .SLW(8), .DLY(D), .PAT(PAT), .ECW(16)
    ) dut (
      .clk(clk), .rst(rst), .start(start_v[k]),
      .base(base_r), .len(len_r),
      .busy(bsy), .done(dn), .err_cnt(ec),
      .tcb(bus.man)
    );

    always @(posedge clk)
      if (bus.trn && bus.wen) mem[bus.adr[7:2]] <= bus.wdt;

    always_comb begin
      cur_dat = mem[bus.adr[7:2]];
      if (!bus.wen && corrupt_idx >= 0 &&
          bus.adr == base_al + 32'(corrupt_idx * 4))
        cur_dat = cur_dat ^ 32'h0000_0100;
      cur_err = (err_mode == 2) ||
                (err_mode == 1 && bus.wen && bus.adr == base_al + 32'd4);
    end

    if (D == 0) begin : g_z
      assign bus.rdt = cur_dat;
      assign bus.err = cur_err;
    end else begin : g_p
      logic [32:0] pp [D];
      always @(posedge clk) begin
        pp[0] <= {cur_err, cur_dat};
        for (int j = 1; j < D; j++) pp[j] <= pp[j-1];
      end
      assign bus.err = pp[D-1][32];
      assign bus.rdt = pp[D-1][31:0];
    end

    always @(posedge clk)
      if (!bus.vld || bus.trn) wc <= 0;
      else if (wc < bp) wc <= wc + 1;
    assign bus.rdy = (wc >= bp);

    assign done_v[k] = dn;
    assign busy_v[k] = bsy;
    assign vld_v[k]  = bus.vld;
    assign wen_v[k]  = bus.wen;
    assign ec_v[k]   = ec;
    assign adr_v[k]  = bus.adr;
    assign wdt_v[k]  = bus.wdt;
    assign ben_v[k]  = bus.ben;

    if (k == 1) begin : g_mon
      logic        pv, pr;
      logic [31:0] pa, pw;
      initial stab_bad = 0;
      always @(posedge clk) begin
        if (bus.trn) ev_q.push_back({bus.wen, bus.adr, bus.wdt});
        if (pv && !pr && bus.vld && (bus.adr != pa || bus.wdt != pw))
          stab_bad = stab_bad + 1;
        pv <= bus.vld;
        pr <= bus.rdy;
        pa <= bus.adr;
        pw <= bus.wdt;
      end
    end
  end

  task automatic run(input int k, input logic [31:0] b,
                     input logic [31:0] n, input bit poke,
                     output int de, output logic [15:0] ec,
                     output bit busy_ok, output bit vld_seen,
                     output bit done_once);
    de = -1;
    ec = '1;
    busy_ok = 1'b1;
    vld_seen = 1'b0;
    @(negedge clk);
    base_r = b;
    base_al = b & ~32'h3;
    len_r = n;
    start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    for (int e = 0; e < 3000; e++) begin
      if (e > 0) @(negedge clk);
      if (vld_v[k]) vld_seen = 1'b1;
      if (poke && e == 3) start_v[k] = 1'b1;
      if (poke && e == 4) start_v[k] = 1'b0;
      if (done_v[k]) begin
        de = e;
        ec = ec_v[k];
        if (busy_v[k]) busy_ok = 1'b0;
        break;
      end
      if (!busy_v[k]) busy_ok = 1'b0;
    end
    @(negedge clk);
    done_once = !done_v[k];
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({vld_v[k], busy_v[k], done_v[k]} !== 3'b000 || ec_v[k] !== 16'd0) begin
        bad++;
        $display("FAIL reset_ctl k=%0d got vbd=%b%b%b ec=%0d want 000 ec=0",
                 k, vld_v[k], busy_v[k], done_v[k], ec_v[k]);
      end
    end
    total++;
    if ({wen_v[1], adr_v[1], wdt_v[1], ben_v[1]} !== 69'd0) begin
      bad++;
      $display("FAIL reset_bus got wen=%b adr=%h wdt=%h ben=%h want zeros",
               wen_v[1], adr_v[1], wdt_v[1], ben_v[1]);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy_v !== 3'b000) begin
      bad++;
      $display("FAIL idle_busy got=%b want=000", busy_v);
    end
  endtask

  task automatic test_timing;
    int de, d, n0;
    logic [15:0] ec;
    bit bo, vs, d1;
    ev_t x;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
      n0 = ev_q.size();
      run(k, 32'h100, 4, 1'b0, de, ec, bo, vs, d1);
      total++;
      if (de !== 2 * 4 + 2 * d + 2 || ec !== 0) begin
        bad++;
        $display("FAIL timing k=%0d got de=%0d ec=%0d want de=%0d ec=0",
                 k, de, ec, 10 + 2 * d);
      end
      total++;
      if (!bo || !d1) begin
        bad++;
        $display("FAIL busy_done k=%0d got busy_ok=%0d once=%0d want 1 1",
                 k, bo, d1);
      end
      if (k == 1) begin
        total++;
        if (ev_q.size() !== n0 + 8) begin
          bad++;
          $display("FAIL trn_count got=%0d want=8", ev_q.size() - n0);
        end else begin
          for (int j = 0; j < 8; j++) begin
            x.wen = (j < 4);
            x.adr = 32'h100 + 32'(4 * (j % 4));
            x.wdt = PAT ^ 32'(j % 4);
            total++;
            if (ev_q[n0 + j] !== x) begin
              bad++;
              $display("FAIL trn_%0d got=%h want=%h", j, ev_q[n0 + j], x);
            end
          end
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int de, n0, s0;
    logic [15:0] ec;
    bit bo, vs, d1;
    ev_t x;
    bp = 2;
    n0 = ev_q.size();
    s0 = stab_bad;
    run(1, 32'h100, 8, 1'b0, de, ec, bo, vs, d1);
    bp = 0;
    total++;
    if (de !== 20 + 32 || ec !== 0) begin
      bad++;
      $display("FAIL bp_timing got de=%0d ec=%0d want de=52 ec=0", de, ec);
    end
    total++;
    if (stab_bad !== s0) begin
      bad++;
      $display("FAIL bp_stable got=%0d changes want=0", stab_bad - s0);
    end
    total++;
    if (ev_q.size() !== n0 + 16) begin
      bad++;
      $display("FAIL bp_count got=%0d want=16", ev_q.size() - n0);
    end else begin
      for (int j = 0; j < 16; j++) begin
        x.wen = (j < 8);
        x.adr = 32'h100 + 32'(4 * (j % 8));
        x.wdt = PAT ^ 32'(j % 8);
        total++;
        if (ev_q[n0 + j] !== x) begin
          bad++;
          $display("FAIL bp_trn_%0d got=%h want=%h", j, ev_q[n0 + j], x);
        end
      end
    end
  endtask

  task automatic test_errors;
    int de, d;
    logic [15:0] ec;
    bit bo, vs, d1;
    corrupt_idx = 2;
    err_mode = 1;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
      run(k, 32'h100, 4, 1'b0, de, ec, bo, vs, d1);
      total++;
      if (ec !== 16'd2 || de !== 10 + 2 * d) begin
        bad++;
        $display("FAIL err_mix k=%0d got ec=%0d de=%0d want ec=2 de=%0d",
                 k, ec, de, 10 + 2 * d);
      end
    end
    err_mode = 2;
    run(1, 32'h100, 4, 1'b0, de, ec, bo, vs, d1);
    total++;
    if (ec !== 16'd8) begin
      bad++;
      $display("FAIL err_all got=%0d want=8", ec);
    end
    err_mode = 0;
    corrupt_idx = -1;
  endtask

  task automatic test_len0;
    int de, n0;
    logic [15:0] ec;
    bit bo, vs, d1;
    run(1, 32'h40, 0, 1'b0, de, ec, bo, vs, d1);
    total++;
    if (de !== 0 || ec !== 0 || vs !== 1'b0) begin
      bad++;
      $display("FAIL len0 got de=%0d ec=%0d vld=%0d want de=0 ec=0 vld=0",
               de, ec, vs);
    end
    n0 = ev_q.size();
    run(1, 32'h100, 4, 1'b1, de, ec, bo, vs, d1);
    total++;
    if (de !== 12 || ev_q.size() !== n0 + 8 || ec !== 0) begin
      bad++;
      $display("FAIL start_busy got de=%0d trn=%0d ec=%0d want 12 8 0",
               de, ev_q.size() - n0, ec);
    end
  endtask

  task automatic test_reset_mid;
    int de;
    logic [15:0] ec;
    bit bo, vs, d1;
    err_mode = 2;
    @(negedge clk);
    base_r = 32'h100;
    base_al = 32'h100;
    len_r = 8;
    start_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if (vld_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || ec_v[1] !== 16'd0) begin
      bad++;
      $display("FAIL rst_mid got vld=%0d busy=%0d ec=%0d want 0 0 0",
               vld_v[1], busy_v[1], ec_v[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ec_v[1] !== 16'd0 || busy_v[1] !== 1'b0) begin
      bad++;
      $display("FAIL late_rsp got ec=%0d busy=%0d want 0 0",
               ec_v[1], busy_v[1]);
    end
    err_mode = 0;
    run(1, 32'h100, 2, 1'b0, de, ec, bo, vs, d1);
    total++;
    if (de !== 8 || ec !== 0) begin
      bad++;
      $display("FAIL after_rst got de=%0d ec=%0d want de=8 ec=0", de, ec);
    end
  endtask

  task automatic test_random;
    int de, d, k, n, n0, want_de;
    logic [31:0] b;
    logic [15:0] ec;
    bit bo, vs, d1;
    ev_t x;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 2);
      d = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
      b = 32'($urandom_range(0, 'h7F));
      n = $urandom_range(1, 16);
      bp = $urandom_range(0, 2);
      corrupt_idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      want_de = 2 * n + 2 * d + 2 + 2 * n * bp;
      n0 = ev_q.size();
      run(k, b, 32'(n), 1'b0, de, ec, bo, vs, d1);
      total++;
      if (de !== want_de || ec !== 16'((corrupt_idx >= 0) ? 1 : 0)) begin
        bad++;
        $display("FAIL rnd%0d k=%0d n=%0d bp=%0d got de=%0d ec=%0d want de=%0d ec=%0d",
                 it, k, n, bp, de, ec, want_de, (corrupt_idx >= 0) ? 1 : 0);
      end
      if (k == 1 && ev_q.size() == n0 + 2 * n) begin
        for (int j = 0; j < 2 * n; j++) begin
          x.wen = (j < n);
          x.adr = (b & ~32'h3) + 32'(4 * (j % n));
          x.wdt = PAT ^ 32'(j % n);
          total++;
          if (ev_q[n0 + j] !== x) begin
            bad++;
            $display("FAIL rnd%0d_trn%0d got=%h want=%h",
                     it, j, ev_q[n0 + j], x);
          end
        end
      end
    end
    bp = 0;
    corrupt_idx = -1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    start_v = '0;
    base_r = '0;
    len_r = '0;
    base_al = '0;
    bp = 0;
    err_mode = 0;
    corrupt_idx = -1;
    repeat (3) @(posedge clk);
    test_reset;
    test_timing;
    test_backpressure;
    test_errors;
    test_len0;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
